// File: rtl/usb_pkg.sv
// Shared USB receive-path constants and types.
package usb_pkg;

  localparam int USB_STUFF_RUN_LEN = 6;
  localparam int USB_WORD_W        = 8;

  // Classification of the bit presented on the input this cycle.
  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_KEEP  = 2'd1,
    BIT_STUFF = 2'd2
  } bit_kind_e;

endpackage

// File: rtl/usb_bit_unstuffer_deser_if.sv
// Serial input stream plus unstuffed/deserialised outputs of the unstuffer.
interface usb_bit_unstuffer_deser_if #(
  parameter int RUN_LEN = usb_pkg::USB_STUFF_RUN_LEN,
  parameter int DATA_W  = usb_pkg::USB_WORD_W
);
  logic                         in_bit;
  logic                         in_valid;
  logic                         in_eop;
  logic                         out_bit;
  logic                         out_valid;
  logic [DATA_W-1:0]            word_data;
  logic                         word_valid;
  logic                         word_last;
  logic [$clog2(DATA_W+1)-1:0]  word_nbits;
  logic                         stuff_err;
  logic [$clog2(RUN_LEN+1)-1:0] one_count;

  modport master (
    output in_bit, in_valid, in_eop,
    input  out_bit, out_valid, word_data, word_valid, word_last,
           word_nbits, stuff_err, one_count
  );

  modport slave (
    input  in_bit, in_valid, in_eop,
    output out_bit, out_valid, word_data, word_valid, word_last,
           word_nbits, stuff_err, one_count
  );
endinterface

// File: rtl/usb_word_assembler.sv
// LSB-first word assembler: collects kept bits, emits full words and
// flushes the partial word at end of packet.
module usb_word_assembler #(
  parameter int DATA_W = usb_pkg::USB_WORD_W,
  localparam int IDX_W = $clog2(DATA_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              flush,
  input  logic              suppress,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  output logic [IDX_W-1:0]  word_nbits
);

  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic              full_s;
  logic              emit_s;

  // Fold this cycle's bit into the word and decide whether a word leaves.
  always_comb begin
    shift_nxt_s = shift_r;
    idx_nxt_s   = idx_r;
    if (shift_en) begin
      shift_nxt_s = shift_r | ({{(DATA_W-1){1'b0}}, shift_bit} << idx_r);
      idx_nxt_s   = idx_r + IDX_W'(1);
    end else begin
      shift_nxt_s = shift_r;
      idx_nxt_s   = idx_r;
    end
    full_s = (idx_nxt_s == IDX_W'(DATA_W));
    // An empty word at eop (e.g. full word already sent) produces nothing.
    emit_s = (full_s || (flush && (idx_nxt_s != {IDX_W{1'b0}}))) && !suppress;
  end

  // Word outputs and assembly state; state clears on a full word or eop
  // even when emission is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= {DATA_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      word_data  <= {DATA_W{1'b0}};
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_nbits <= {IDX_W{1'b0}};
    end else begin
      if (emit_s) begin
        word_data  <= shift_nxt_s;
        word_valid <= 1'b1;
        word_last  <= flush;
        word_nbits <= idx_nxt_s;
      end else begin
        word_data  <= {DATA_W{1'b0}};
        word_valid <= 1'b0;
        word_last  <= 1'b0;
        word_nbits <= {IDX_W{1'b0}};
      end
      if (full_s || flush) begin
        shift_r <= {DATA_W{1'b0}};
        idx_r   <= {IDX_W{1'b0}};
      end else begin
        shift_r <= shift_nxt_s;
        idx_r   <= idx_nxt_s;
      end
    end
  end

endmodule

// File: rtl/usb_bit_unstuffer_deser.sv
// USB receive bit unstuffer with LSB-first deserialiser.
// Optional feature macro: USB_UNSTUFF_ERR_EN (stuff-violation detection and
// per-packet word suppression). Without it, stuffed bits are dropped blindly.
module usb_bit_unstuffer_deser
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN_LEN,
  parameter int DATA_W  = USB_WORD_W
) (
  input  logic                     clk,
  input  logic                     RST,
  usb_bit_unstuffer_deser_if.slave bus
);

  localparam int CNT_W = $clog2(RUN_LEN+1);

  bit_kind_e         bit_kind_s;
  logic [CNT_W-1:0]  one_count_r;
  logic [CNT_W-1:0]  one_count_nxt_s;
  logic              out_bit_r;
  logic              out_valid_r;
  logic              eop_s;
  logic              suppress_s;

  // Classify the incoming bit and compute the next run-of-ones count.
  always_comb begin
    bit_kind_s      = BIT_IDLE;
    one_count_nxt_s = one_count_r;
    if (bus.in_valid) begin
      if (one_count_r == CNT_W'(RUN_LEN)) begin
        bit_kind_s      = BIT_STUFF;
        one_count_nxt_s = {CNT_W{1'b0}};
      end else begin
        bit_kind_s      = BIT_KEEP;
        one_count_nxt_s = bus.in_bit ? (one_count_r + CNT_W'(1)) : {CNT_W{1'b0}};
      end
      if (bus.in_eop) begin
        one_count_nxt_s = {CNT_W{1'b0}};
      end else begin
        one_count_nxt_s = one_count_nxt_s;
      end
    end else begin
      bit_kind_s      = BIT_IDLE;
      one_count_nxt_s = one_count_r;
    end
  end

  assign eop_s = bus.in_valid & bus.in_eop;

  // Run counter and registered serial output.
  always_ff @(posedge clk) begin
    if (RST) begin
      one_count_r <= {CNT_W{1'b0}};
      out_bit_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      one_count_r <= one_count_nxt_s;
      out_valid_r <= (bit_kind_s == BIT_KEEP);
      out_bit_r   <= (bit_kind_s == BIT_KEEP) ? bus.in_bit : 1'b0;
    end
  end

`ifdef USB_UNSTUFF_ERR_EN
  logic stuff_hit_s;
  logic err_flag_r;
  logic stuff_err_r;

  assign stuff_hit_s = (bit_kind_s == BIT_STUFF) & bus.in_bit;
  // Suppress on the violating bit itself too, so an eop on it drops the flush.
  assign suppress_s  = err_flag_r | stuff_hit_s;

  // Sticky per-packet error flag and one-cycle violation pulse.
  always_ff @(posedge clk) begin
    if (RST) begin
      err_flag_r  <= 1'b0;
      stuff_err_r <= 1'b0;
    end else begin
      stuff_err_r <= stuff_hit_s;
      if (eop_s) begin
        err_flag_r <= 1'b0;
      end else if (stuff_hit_s) begin
        err_flag_r <= 1'b1;
      end else begin
        err_flag_r <= err_flag_r;
      end
    end
  end

  assign bus.stuff_err = stuff_err_r;
`else
  assign suppress_s    = 1'b0;
  assign bus.stuff_err = 1'b0;
`endif

  assign bus.out_bit   = out_bit_r;
  assign bus.out_valid = out_valid_r;
  assign bus.one_count = one_count_r;

  usb_word_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk        (clk),
    .rst        (RST),
    .shift_en   (bit_kind_s == BIT_KEEP),
    .shift_bit  (bus.in_bit),
    .flush      (eop_s),
    .suppress   (suppress_s),
    .word_data  (bus.word_data),
    .word_valid (bus.word_valid),
    .word_last  (bus.word_last),
    .word_nbits (bus.word_nbits)
  );

endmodule

// File: tb/tb_usb_bit_unstuffer_deser.sv
// Scoreboard bench for usb_bit_unstuffer_deser (RUN_LEN=6, DATA_W=8).
module tb_usb_bit_unstuffer_deser;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] nbits;
    logic       last;
  } word_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   err_cnt;
  int   max_cnt;

  logic  exp_bits[$];
  word_t exp_words[$];

  usb_bit_unstuffer_deser_if #(.RUN_LEN(6), .DATA_W(8)) bus ();

  usb_bit_unstuffer_deser #(.RUN_LEN(6), .DATA_W(8)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Present one bit for one cycle; keep says whether it should be output.
  task automatic send(input logic b, input logic eop, input logic keep);
    if (keep) exp_bits.push_back(b);
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    bus.in_eop   = eop;
    @(posedge clk);
    #1;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_word(input logic [7:0] d, input logic [3:0] nb, input logic l);
    word_t w;
    w.data = d; w.nbits = nb; w.last = l;
    exp_words.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic eop_last);
    for (int i = 0; i < 8; i++) send(v[i], eop_last && (i == 7), 1'b1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents output.
  always @(negedge clk) begin
    if (bus.stuff_err) err_cnt++;
    if (int'(bus.one_count) > max_cnt) max_cnt = int'(bus.one_count);
    if (bus.out_valid) begin
      if (exp_bits.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_bit", int'(bus.out_bit), int'(exp_bits.pop_front()));
      end
    end
    if (bus.word_valid) begin
      if (exp_words.size() == 0) begin
        check("unexpected_word_valid", int'(bus.word_data), -1);
      end else begin
        word_t w;
        w = exp_words.pop_front();
        check("word_data", int'(bus.word_data), int'(w.data));
        check("word_nbits", int'(bus.word_nbits), int'(w.nbits));
        check("word_last", int'(bus.word_last), int'(w.last));
      end
    end else begin
      check("word_fields_idle_zero",
            int'({bus.word_data, bus.word_nbits, bus.word_last}), 0);
    end
  end

  initial begin
    int e4;
    n_vec = 0; n_bad = 0; err_cnt = 0; max_cnt = 0;
    bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.in_eop = 1'b0;
    rst = 1'b1;
    idle(2);
    check("reset_outputs",
          int'({bus.out_bit, bus.out_valid, bus.word_data, bus.word_valid,
                bus.word_last, bus.word_nbits, bus.stuff_err, bus.one_count}), 0);
    rst = 1'b0;
    idle(1);

    // Test 1: 20-bit packet, zeros at 6, 12, 13; bit 6 is the stuffed bit.
    err_cnt = 0; max_cnt = 0;
    exp_word(8'hFF, 4'd8, 1'b0);
    exp_word(8'hE7, 4'd8, 1'b0);
    exp_word(8'h07, 4'd3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send((i == 6 || i == 12 || i == 13) ? 1'b0 : 1'b1, i == 19, i != 6);
    end
    idle(2);
    check("t1_stuff_err_cnt", err_cnt, 0);
    check("t1_one_count_max_ok", int'(max_cnt <= 6), 1);
    check("t1_one_count_after_eop", int'(bus.one_count), 0);

    // Test 2: 0xA5 in one packet.
    exp_word(8'hA5, 4'd8, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(2);

    // Test 3: 11 bits -> 0x55 then 3-bit 0x3 with last.
    exp_word(8'h55, 4'd8, 1'b0);
    exp_word(8'h03, 4'd3, 1'b1);
    begin
      logic [10:0] pat;
      pat = 11'b011_0101_0101;
      for (int i = 0; i < 11; i++) send(pat[i], i == 10, 1'b1);
    end
    idle(2);

    // Test 4: seven ones (violation on the 7th), then 0, 0 with eop.
    err_cnt = 0;
`ifdef USB_UNSTUFF_ERR_EN
    e4 = 1;
`else
    e4 = 0;
    exp_word(8'h3F, 4'd8, 1'b1);
`endif
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 1'b1);
    check("t4_one_count_6", int'(bus.one_count), 6);
    send(1'b1, 1'b0, 1'b0);
    check("t4_one_count_0", int'(bus.one_count), 0);
    send(1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b1, 1'b1);
    idle(2);
    check("t4_stuff_err_cnt", err_cnt, e4);

    // Test 5: reset mid-packet, then 0xFF packet with a stuffed zero.
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_outputs_after_rst",
          int'({bus.out_bit, bus.out_valid, bus.word_data, bus.word_valid,
                bus.word_last, bus.word_nbits, bus.stuff_err, bus.one_count}), 0);
    rst = 1'b0;
    idle(1);
    exp_word(8'hFF, 4'd8, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b1);
    idle(2);

    // Test 6: 0x3C with 3 idle cycles between bits.
    exp_word(8'h3C, 4'd8, 1'b1);
    begin
      logic [7:0] v;
      v = 8'h3C;
      for (int i = 0; i < 8; i++) begin
        send(v[i], i == 7, 1'b1);
        if (i < 7) idle(3);
        if (i == 5) check("t6_one_count_kept_over_gap", int'(bus.one_count), 4);
      end
    end
    idle(3);

    check("bits_left_in_scoreboard", exp_bits.size(), 0);
    check("words_left_in_scoreboard", exp_words.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
